filter_ctrl: RTL and testbench
==============================

FILTER_CTRL -- requirements
Module: filter_ctrl

Interface
REQ-001 Parameter DATABITS, default 16, sample/coefficient width, two's complement Q(DATABITS-1).
REQ-002 Parameter ACCBITS, default 40, accumulator width; SHALL be >= 2*DATABITS+$clog2(TAPS).
REQ-003 Parameter TAPS, default 8, filter length; SHALL be a power of two, >= 2.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 in_valid  in  1  input sample offered.
REQ-007 in_ready  out  1  block can accept a sample.
REQ-008 in_data  in  DATABITS  signed input sample.
REQ-009 out_valid  out  1  filtered result available.
REQ-010 out_ready  in  1  consumer accepts result.
REQ-011 out_data  out  DATABITS  signed saturated result.
REQ-012 coef_we  in  1  coefficient write strobe.
REQ-013 coef_addr  in  $clog2(TAPS)  coefficient index k.
REQ-014 coef_in  in  DATABITS  coefficient value.
REQ-015 clr_in  in  1  clear the sample delay line.
REQ-016 m1_out  out  DATABITS  ALU operand 1 (sample).
REQ-017 m2_out  out  DATABITS  ALU operand 2 (coefficient).
REQ-018 cmd_out  out  alu_cmd_t  ALU command.
REQ-019 acc_out  out  ACCBITS  ALU accumulator operand; always equals internal acc register.
REQ-020 alu_d_in  in  ACCBITS  combinational ALU result for current cmd_out/operands.

Function
REQ-021 FSM states: IDLE, MAC, SAT, OUT; in_ready SHALL be 1 only in IDLE.
REQ-022 IDLE: cmd_out=ALU_NOP, m1_out=m2_out=0; on in_valid&&in_ready, in_data written to delay line at wr_ptr, wr_ptr increments mod TAPS (wrap TAPS-1 -> 0), k<=0, go MAC.
REQ-023 MAC cycle k (k=0..TAPS-1): m1_out=x[n-k] (newest sample when k=0, delay-line index (newest_ptr-k) mod TAPS), m2_out=coef[k], cmd_out=ALU_MU when k=0 else ALU_ADMU; acc<=alu_d_in.
REQ-024 After k=TAPS-1, go SAT; SAT: cmd_out=ALU_SATA, m1_out=m2_out=0, out_data<=alu_d_in[DATABITS-1:0], go OUT.
REQ-025 OUT: out_valid=1, out_data held stable; on out_ready go IDLE with out_valid=0 next cycle.
REQ-026 Latency: sample accepted in cycle c -> MAC in c+1..c+TAPS, SAT in c+TAPS+1, out_valid first high in c+TAPS+2; minimum sample period TAPS+3 cycles.
REQ-027 Result = sat(sum_k x[n-k]*coef[k] >>> (DATABITS-1)) to [-2^(DATABITS-1), 2^(DATABITS-1)-1], arithmetic shift (floor).
REQ-028 coef_we honoured only in IDLE; ignored in MAC/SAT/OUT; a write in the same cycle as sample accept SHALL be used by that sample's computation.
REQ-029 clr_in honoured only in IDLE: all delay-line entries <=0, wr_ptr<=0; if same cycle as accept, the accepted sample lands at index 0 and all other entries are 0.
REQ-030 in_valid while in_ready=0 SHALL not change any state.
REQ-031 Coefficients and delay line persist across samples; only rst or clr_in (delay line) alter them.

Reset
REQ-032 On rst: state IDLE, delay line and coefficients 0, wr_ptr 0, acc 0, out_valid 0, out_data 0, cmd_out ALU_NOP, m1_out/m2_out 0, in_ready 1 in next cycle.
REQ-033 rst in any state aborts the computation; no out_valid for the aborted sample; rst has priority over all inputs.

Verification (TAPS=4, DATABITS=16, ACCBITS=40, real ALU attached)
REQ-034 Impulse: coef=[16384,8192,4096,2048], inputs 32767,0,0,0,0 -> outputs 16383,8191,4095,2047,0 (5th sample exercises wr_ptr wrap).
REQ-035 Saturation: all coef=32767, four inputs 32767 -> 4th output 32767; after clr, four inputs -32768 -> 4th output -32768.
REQ-036 Backpressure: out_ready=0 for 10 cycles in OUT -> out_valid=1, out_data constant, in_ready=0, in_valid pulses ignored; then out_ready=1 -> IDLE next cycle.
REQ-037 Coefficient timing: coef_we to k=0 during MAC ignored (result unchanged); coef_we in accept cycle -> result uses new value; latency check out_valid exactly c+6.
REQ-038 Reset mid-MAC (cycle c+2): no out_valid; delay line cleared; next impulse reproduces REQ-034 sequence.

Source files
------------

// File: rtl/filter_ctrl.sv
// filter_ctrl: sequencer for a TAPS-tap FIR filter that drives an external
// multiply-accumulate ALU. Samples go into a circular delay line. Each sample
// takes TAPS MAC cycles, then one saturate cycle, then an output hold state.
//
// Latency: a sample accepted in cycle c gives out_valid in cycle c+TAPS+2.
//   The minimum sample period is TAPS+3 cycles.
// Backpressure: in_ready is high only in IDLE. OUT holds out_valid and
//   out_data until out_ready is seen.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_valid/in_ready/in_data     sample input handshake
//   out_valid/out_ready/out_data  saturated result handshake
//   coef_we/coef_addr/coef_in     coefficient write port (IDLE only)
//   clr_in                        clear delay line (IDLE only)
//   m1_out/m2_out/cmd_out/acc_out operands and command to the external ALU
//   alu_d_in                      combinational ALU result

package filter_ctrl_pkg;
  typedef enum logic [1:0] {
    ALU_NOP  = 2'd0,  // d = acc
    ALU_MU   = 2'd1,  // d = m1 * m2
    ALU_ADMU = 2'd2,  // d = acc + m1 * m2
    ALU_SATA = 2'd3   // d = sat(acc >>> (DATABITS-1))
  } alu_cmd_t;
endpackage

module filter_ctrl
  import filter_ctrl_pkg::*;
#(
  parameter int DATABITS = 16,
  parameter int ACCBITS  = 40,
  parameter int TAPS     = 8,
  localparam int AW      = $clog2(TAPS)
) (
  input  logic                clk,
  input  logic                rst,
  // sample input
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATABITS-1:0] in_data,
  // result output
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATABITS-1:0] out_data,
  // coefficient write port
  input  logic                coef_we,
  input  logic [AW-1:0]       coef_addr,
  input  logic [DATABITS-1:0] coef_in,
  // delay-line clear
  input  logic                clr_in,
  // ALU interface
  output logic [DATABITS-1:0] m1_out,
  output logic [DATABITS-1:0] m2_out,
  output alu_cmd_t            cmd_out,
  output logic [ACCBITS-1:0]  acc_out,
  input  logic [ACCBITS-1:0]  alu_d_in
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_SAT  = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  state_t              state_q, state_d;

  logic [DATABITS-1:0] dline_q [TAPS];
  logic [DATABITS-1:0] coef_q  [TAPS];
  logic [AW-1:0]       wr_ptr_q;   // slot that receives the next sample
  logic [AW-1:0]       newest_q;   // slot that holds the sample being filtered
  logic [AW-1:0]       k_q;        // current tap index during MAC
  logic [ACCBITS-1:0]  acc_q;
  logic [DATABITS-1:0] out_data_q;

  logic                idle;
  logic                accept;
  logic                last_tap;
  logic [AW-1:0]       wr_slot;
  logic [AW-1:0]       rd_idx;

  assign idle     = (state_q == ST_IDLE);
  assign accept   = idle && in_valid;
  assign last_tap = (k_q == AW'(TAPS - 1));

  // A clear in the accept cycle moves the write pointer back to slot 0. The
  // new sample then lands at index 0 of a zeroed line.
  assign wr_slot  = clr_in ? '0 : wr_ptr_q;

  // TAPS is a power of two, so AW-bit subtraction wraps mod TAPS.
  assign rd_idx   = newest_q - k_q;

  assign in_ready  = idle;
  assign out_valid = (state_q == ST_OUT);
  assign out_data  = out_data_q;
  assign acc_out   = acc_q;

  // ---------------------------------------------------------------------------
  // Next state and ALU drive
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cmd_out = ALU_NOP;
    m1_out  = '0;
    m2_out  = '0;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_MAC;
        end
      end

      ST_MAC: begin
        m1_out  = dline_q[rd_idx];
        m2_out  = coef_q[k_q];
        // The first tap loads the accumulator. Later taps add into it.
        cmd_out = (k_q == '0) ? ALU_MU : ALU_ADMU;
        if (last_tap) begin
          state_d = ST_SAT;
        end
      end

      ST_SAT: begin
        cmd_out = ALU_SATA;
        state_d = ST_OUT;
      end

      ST_OUT: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Delay line, pointers and tap counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) begin
        dline_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      newest_q <= '0;
      k_q      <= '0;
    end else begin
      if (idle && clr_in) begin
        for (int i = 0; i < TAPS; i++) begin
          dline_q[i] <= '0;
        end
        wr_ptr_q <= '0;
      end

      // This comes after the clear so the accepted sample overrides slot 0.
      if (accept) begin
        dline_q[wr_slot] <= in_data;
        newest_q         <= wr_slot;
        wr_ptr_q         <= wr_slot + AW'(1);
        k_q              <= '0;
      end else if (state_q == ST_MAC) begin
        k_q <= k_q + AW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Coefficient store. It is written only in IDLE, so a running computation
  // always sees one consistent set.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) begin
        coef_q[i] <= '0;
      end
    end else if (idle && coef_we) begin
      coef_q[coef_addr] <= coef_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Accumulator and output register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q      <= '0;
      out_data_q <= '0;
    end else begin
      if (state_q == ST_MAC) begin
        acc_q <= alu_d_in;
      end
      // In SAT the ALU already returns the clamped value in its low bits.
      if (state_q == ST_SAT) begin
        out_data_q <= alu_d_in[DATABITS-1:0];
      end
    end
  end

endmodule

// File: tb/tb_filter_ctrl.sv
// tb_filter_ctrl: drives filter_ctrl with TAPS=4 and a behavioural ALU
// attached. Directed scenarios are followed by random samples and
// coefficients. Results are compared against a FIR sum-of-products model.

module tb_filter_ctrl;
  import filter_ctrl_pkg::*;

  localparam int DATABITS = 16;
  localparam int ACCBITS  = 40;
  localparam int TAPS     = 4;
  localparam int AW       = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic [DATABITS-1:0] in_data;
  logic                out_valid;
  logic                out_ready;
  logic [DATABITS-1:0] out_data;
  logic                coef_we;
  logic [AW-1:0]       coef_addr;
  logic [DATABITS-1:0] coef_in;
  logic                clr_in;
  logic [DATABITS-1:0] m1_out;
  logic [DATABITS-1:0] m2_out;
  alu_cmd_t            cmd_out;
  logic [ACCBITS-1:0]  acc_out;
  logic [ACCBITS-1:0]  alu_d_in;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  filter_ctrl #(.DATABITS(DATABITS), .ACCBITS(ACCBITS), .TAPS(TAPS)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_in(coef_in),
    .clr_in(clr_in),
    .m1_out(m1_out), .m2_out(m2_out), .cmd_out(cmd_out), .acc_out(acc_out),
    .alu_d_in(alu_d_in)
  );

  // Behavioural ALU attached to the controller
  localparam logic signed [ACCBITS-1:0] SMAX = 32767;
  localparam logic signed [ACCBITS-1:0] SMIN = -32768;
  logic signed [ACCBITS-1:0] prod, shifted;
  always_comb begin
    prod     = $signed(m1_out) * $signed(m2_out);
    shifted  = $signed(acc_out) >>> (DATABITS - 1);
    alu_d_in = acc_out;
    case (cmd_out)
      ALU_MU:   alu_d_in = prod;
      ALU_ADMU: alu_d_in = $signed(acc_out) + prod;
      ALU_SATA: begin
        if (shifted > SMAX)      alu_d_in = SMAX;
        else if (shifted < SMIN) alu_d_in = SMIN;
        else                     alu_d_in = shifted;
      end
      default:  alu_d_in = acc_out;
    endcase
  end

  // Reference model: hist_m[k] is x[n-k] and coef_m[k] is coef[k]
  int coef_m [TAPS];
  int hist_m [TAPS];

  function automatic longint model_result();
    longint s = 0;
    for (int k = 0; k < TAPS; k++) s += longint'(hist_m[k]) * longint'(coef_m[k]);
    s = s >>> (DATABITS - 1);
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    return s;
  endfunction

  task automatic model_clear_all();
    for (int k = 0; k < TAPS; k++) begin
      coef_m[k] = 0;
      hist_m[k] = 0;
    end
  endtask

  task automatic check(input string tag, input longint obs, input longint exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    model_clear_all();
  endtask

  task automatic wr_coef(input int addr, input int val);
    coef_we   = 1'b1;
    coef_addr = AW'(addr);
    coef_in   = DATABITS'(val);
    tick();
    coef_we = 1'b0;
    coef_m[addr] = val;
  endtask

  // Offers one sample at the current negedge in IDLE. The task returns at the
  // negedge where out_valid is first seen, or when the cycle budget expires.
  // mac_wr requests a coefficient write to tap 0 during the first MAC cycle,
  // which the DUT must ignore.
  task automatic send(input int x, input bit clr, input bit wr, input int waddr,
                      input int wval, input bit mac_wr, output longint res);
    int     lat;
    longint exp;
    check("in_ready_before_accept", longint'(in_ready), 1);
    in_valid  = 1'b1;
    in_data   = DATABITS'(x);
    clr_in    = clr;
    coef_we   = wr;
    coef_addr = AW'(waddr);
    coef_in   = DATABITS'(wval);
    if (wr) coef_m[waddr] = wval;
    if (clr) for (int k = 0; k < TAPS; k++) hist_m[k] = 0;
    for (int k = TAPS - 1; k > 0; k--) hist_m[k] = hist_m[k-1];
    hist_m[0] = x;
    exp = model_result();
    tick();
    in_valid = 1'b0;
    clr_in   = 1'b0;
    coef_we  = 1'b0;
    lat = 1;
    if (mac_wr) begin
      coef_we   = 1'b1;
      coef_addr = '0;
      coef_in   = DATABITS'(12345);
    end
    while (!out_valid && lat < 20) begin
      tick();
      coef_we = 1'b0;
      lat++;
    end
    check("latency", lat, TAPS + 2);
    res = longint'($signed(out_data));
    check("result", res, exp);
  endtask

  task automatic finish_out();
    tick();
    check("out_valid_after_hs", longint'(out_valid), 0);
    check("in_ready_after_hs", longint'(in_ready), 1);
  endtask

  longint r;
  longint held;
  int     impulse_in  [5] = '{32767, 0, 0, 0, 0};
  int     impulse_exp [5] = '{16383, 8191, 4095, 2047, 0};
  int     impulse_cf  [4] = '{16384, 8192, 4096, 2048};
  int     seen;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    coef_we = 1'b0; coef_addr = '0; coef_in = '0; clr_in = 1'b0;
    tick();
    do_reset();

    // Reset state
    check("rst_in_ready", longint'(in_ready), 1);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_out_data", longint'(out_data), 0);
    check("rst_cmd", longint'(cmd_out), longint'(ALU_NOP));
    check("rst_m1", longint'(m1_out), 0);
    check("rst_m2", longint'(m2_out), 0);
    check("rst_acc", longint'(acc_out), 0);

    // Impulse response, including a wrap of the write pointer
    for (int i = 0; i < TAPS; i++) wr_coef(i, impulse_cf[i]);
    for (int i = 0; i < 5; i++) begin
      send(impulse_in[i], 1'b0, 1'b0, 0, 0, 1'b0, r);
      check("impulse_const", r, impulse_exp[i]);
      finish_out();
    end

    // Positive saturation
    for (int i = 0; i < TAPS; i++) wr_coef(i, 32767);
    for (int i = 0; i < 4; i++) begin
      send(32767, (i == 0), 1'b0, 0, 0, 1'b0, r);
      finish_out();
    end
    check("sat_pos", r, 32767);
    // Negative saturation after a clear
    for (int i = 0; i < 4; i++) begin
      send(-32768, (i == 0), 1'b0, 0, 0, 1'b0, r);
      finish_out();
    end
    check("sat_neg", r, -32768);

    // Backpressure: hold OUT for 10 cycles and pulse in_valid
    for (int i = 0; i < TAPS; i++) wr_coef(i, impulse_cf[i]);
    out_ready = 1'b0;
    send(1000, 1'b1, 1'b0, 0, 0, 1'b0, r);
    held = r;
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      in_data  = DATABITS'($urandom);
      tick();
      check("bp_out_valid", longint'(out_valid), 1);
      check("bp_out_data", longint'($signed(out_data)), held);
      check("bp_in_ready", longint'(in_ready), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    finish_out();
    // Ignored pulses must not have entered the delay line
    send(2000, 1'b0, 1'b0, 0, 0, 1'b0, r);
    finish_out();

    // A coefficient write during MAC is ignored
    send(3000, 1'b0, 1'b0, 0, 0, 1'b1, r);
    finish_out();
    // A coefficient write in the accept cycle is used
    send(4000, 1'b0, 1'b1, 0, -20000, 1'b0, r);
    finish_out();

    // Reset in the middle of MAC
    in_valid = 1'b1; in_data = DATABITS'(5000);
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_clear_all();
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) seen++;
      tick();
    end
    check("rst_mid_no_out_valid", seen, 0);
    check("rst_mid_acc", longint'(acc_out), 0);
    for (int i = 0; i < TAPS; i++) wr_coef(i, impulse_cf[i]);
    for (int i = 0; i < 5; i++) begin
      send(impulse_in[i], 1'b0, 1'b0, 0, 0, 1'b0, r);
      check("impulse_after_rst", r, impulse_exp[i]);
      finish_out();
    end

    // Random samples, coefficients and clears
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0)
        wr_coef(int'($urandom_range(0, TAPS - 1)), int'($urandom_range(0, 65535)) - 32768);
      send(int'($urandom_range(0, 65535)) - 32768, ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 4) == 0), int'($urandom_range(0, TAPS - 1)),
           int'($urandom_range(0, 65535)) - 32768, ($urandom_range(0, 4) == 0), r);
      finish_out();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
